// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder and any decoder-side logic.
// Holds op codes, the compare command, the always condition, the field bit
// positions of the 32-bit instruction word, and the input field-set payload.
package instr_encoder_pkg;

    localparam logic [1:0] OP_DATA    = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] OP_BRANCH  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [3:0] CMD_CMP = 4'd10;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Field positions inside the encoded word
    localparam int unsigned COND_LSB = 28;
    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned IMM_BIT  = 25;
    localparam int unsigned CMD_LSB  = 21;
    localparam int unsigned S_BIT    = 20;
    localparam int unsigned RN_LSB   = 16;
    localparam int unsigned RD_LSB   = 12;
    localparam int unsigned OFF12_W  = 12;
    localparam int unsigned OFF24_W  = 24;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [3:0]  cmd;
        logic        set_flag;
        logic        imm_sel;
        logic [3:0]  src_addr;
        logic [3:0]  dest_reg;
        logic [11:0] imm_mem;
        logic [23:0] imm_br;
    } fields_t;

    function automatic logic is_legal(input logic [1:0] op);
        return op != OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/encoder_fifo.sv
// Output FIFO for encoded words: DEPTH entries (power of two), W bits each.
// Ports: clk, rst (async active-high), push/wdata write side, pop read side
// (ignored when empty), rdata head (0 when empty), valid = non-empty,
// level = occupancy. A push while full is taken only with a same-cycle pop.
module encoder_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] count;
    logic          pop_ok;
    logic          push_ok;

    assign valid   = (count != '0);
    assign pop_ok  = pop && valid;
    assign push_ok = push && ((count < LW'(DEPTH)) || pop_ok);
    assign rdata   = valid ? mem[rptr] : '0;
    assign level   = count;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: rdata is masked while empty
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs an instruction field set into a 32-bit word and queues it, tagged
// with its instruction-memory address, in an output FIFO.
// Ports: clk, rst (async active-high); in_valid/in_ready handshake with the
// field inputs op, cmd, set_flag, imm_sel, src_addr, dest_reg, imm_instr_mem,
// imm_instr (and cond when COND_FIELD_EN is defined); out_valid/out_ready
// handshake with instr/addr at the FIFO head; err pulses one cycle after an
// illegal op is accepted; level is the FIFO occupancy.
// Build option: COND_FIELD_EN adds the cond port; otherwise cond is "always".
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [3:0]             cmd,
    input  logic                   set_flag,
    input  logic                   imm_sel,
    input  logic [3:0]             src_addr,
    input  logic [3:0]             dest_reg,
    input  logic [11:0]            imm_instr_mem,
    input  logic [23:0]            imm_instr,
`ifdef COND_FIELD_EN
    input  logic [3:0]             cond,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            instr,
    output logic [AW-1:0]          addr,
    output logic                   err,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    fields_t        f;
    logic [31:0]    word;
    logic [AW-1:0]  wr_addr;
    logic           accept;
    logic           push;

`ifdef COND_FIELD_EN
    assign f.cond = cond;
`else
    assign f.cond = COND_AL;
`endif
    assign f.op       = op;
    assign f.cmd      = cmd;
    assign f.set_flag = set_flag;
    assign f.imm_sel  = imm_sel;
    assign f.src_addr = src_addr;
    assign f.dest_reg = dest_reg;
    assign f.imm_mem  = imm_instr_mem;
    assign f.imm_br   = imm_instr;

    // Held low through reset; a pop at full frees a slot in the same cycle
    assign in_ready = !rst && ((level < LW'(DEPTH)) || (out_valid && out_ready));
    assign accept   = in_valid && in_ready;
    assign push     = accept && is_legal(f.op);

    // Combinational packing of the field set
    always_comb begin
        word = '0;
        word[COND_LSB +: 4] = f.cond;
        word[OP_LSB +: 2]   = f.op;
        case (f.op)
            OP_DATA: begin
                word[CMD_LSB +: 4] = f.cmd;
                word[S_BIT]        = f.set_flag || (f.cmd == CMD_CMP);
                word[RN_LSB +: 4]  = f.src_addr;
                word[RD_LSB +: 4]  = f.dest_reg;
            end
            OP_MEM: begin
                word[IMM_BIT]      = f.imm_sel;
                word[S_BIT]        = f.set_flag;
                word[RN_LSB +: 4]  = f.src_addr;
                word[RD_LSB +: 4]  = f.dest_reg;
                if (f.imm_sel) word[OFF12_W-1:0] = f.imm_mem;
            end
            OP_BRANCH: begin
                word[OFF24_W-1:0]  = f.imm_br;
            end
            default: word = '0;
        endcase
    end

    // Address counter advances only on legal pushes; err flags dropped sets
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            err     <= 1'b0;
        end else begin
            err <= accept && !is_legal(f.op);
            if (push) wr_addr <= wr_addr + AW'(1);
        end
    end

    encoder_fifo #(
        .DEPTH (DEPTH),
        .W     (32 + AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({wr_addr, word}),
        .pop   (out_ready),
        .rdata ({addr, instr}),
        .valid (out_valid),
        .level (level)
    );

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving output FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter AW, default 8, giving the instruction-address width.
REQ-003 Ports SHALL be:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  field set present.
- in_ready  output  1  field set accepted when in_valid && in_ready.
- op  input  2  00 data, 01 memory, 10 branch, 11 illegal.
- cmd  input  4  data-processing command.
- set_flag  input  1  S bit (op 00) / load bit (op 01).
- imm_sel  input  1  I bit, bit 25.
- src_addr  input  4  Rn.
- dest_reg  input  4  Rd.
- imm_instr_mem  input  12  memory offset.
- imm_instr  input  24  branch offset.
- cond  input  4  condition field, present only with COND_FIELD_EN.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- instr  output  32  encoded word at FIFO head.
- addr  output  AW  instruction-memory address of head.
- err  output  1  one-cycle pulse on an illegal field set.
- level  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-004 Bits [31:28] SHALL be cond; bits [27:26] SHALL be op; all bits not listed for an op SHALL be 0.
REQ-005 For op 00, the word SHALL carry cmd at [24:21], set_flag at [20], src_addr at [19:16] and dest_reg at [15:12].
REQ-006 For op 00 with cmd 10 (compare), bit 20 SHALL be forced to 1.
REQ-007 For op 01, the word SHALL carry imm_sel at [25], set_flag at [20], src_addr at [19:16] and dest_reg at [15:12].
REQ-008 For op 01, bits [11:0] SHALL be imm_instr_mem when imm_sel is 1, else 0.
REQ-009 For op 10, bits [23:0] SHALL be imm_instr.
REQ-010 For op 11, the field set SHALL be accepted and dropped, nothing SHALL be written, and err SHALL pulse high the next cycle.
REQ-011 An accepted legal field set SHALL be encoded and written into the FIFO in the accept cycle, with out_valid at the next edge (latency 1).
REQ-012 in_ready SHALL equal (level < DEPTH) || (out_valid && out_ready).
- Simultaneous push and pop at full SHALL keep the FIFO full without loss.
REQ-013 out_valid SHALL equal (level != 0), and instr/addr SHALL be held stable while out_valid && !out_ready.
REQ-014 Each FIFO entry SHALL store the write address, taken from a counter that increments per legal push and wraps from 2^AW-1 to 0.
REQ-015 Simultaneous push and pop at empty SHALL yield out_valid next cycle; no bypass.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-017 While rst is high, outputs SHALL be: out_valid 0, level 0, err 0, instr 0, addr 0 and in_ready 0; the address counter and pointers SHALL be 0.
REQ-018 Reset mid-operation SHALL discard all FIFO contents, and in_ready SHALL rise the first cycle after release.

Configuration
REQ-019 With COND_FIELD_EN defined, the cond port SHALL exist and drive bits [31:28].
REQ-020 Without COND_FIELD_EN, the cond port SHALL be absent and bits [31:28] SHALL be 4'b1110 (always).

Structure
REQ-021 A shared package SHALL hold the op encodings (OP_DATA, OP_MEM, OP_BRANCH), CMD_CMP = 4'd10, COND_AL = 4'b1110 and the field bit positions, for reuse by decoder_control-side logic.
REQ-022 The FIFO SHALL be a sub-module named encoder_fifo; packing SHALL be combinational inside instr_encoder.

Verification
REQ-023 Data op: op 00, cmd 4, set_flag 0, Rn 1, Rd 2, out_ready 1 -> instr 0xE0800000|0x00012000 = 0xE0812000, addr 0.
REQ-024 Compare op: op 00, cmd 10, set_flag 0, Rn 3 -> bit 20 = 1, instr 0xE1530000.
REQ-025 Loads: op 01, imm_sel 1, load, Rn 5, Rd 6, off 0x04 -> 0xE6156004; the same with imm_sel 0 -> 0xE4156000.
REQ-026 Branch with illegal op: op 10, imm 0x000010 -> 0xE8000010; then op 11 -> err pulses once, level unchanged, next legal word has addr +1 only.
REQ-027 Backpressure: hold out_ready 0 and push 5 sets -> in_ready low after 4, head stable; pop plus push at full -> level stays 4, order preserved.
REQ-028 Wrap and reset: 256 legal words -> addr wraps 255 -> 0; assert rst with level 3 -> level 0 and out_valid 0 immediately.
